icon_sched: RTL and testbench
=============================

ICON_SCHED -- requirements
Module: icon_sched

Interface
REQ-001 Parameter BLINK_FRAMES, default 16, frames per blink half-period (range 1..255).
REQ-002 Parameter VSYNC_ACTIVE_LOW, default 1, 1 = vsync input asserts low.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 upd_sysregs  input  1  one-cycle pulse: new Rojobot registers valid on *_in.
REQ-006 botinfo_in  input  8  Rojobot orientation/status register; [2:0] orientation, [7:4] status.
REQ-007 locx_in  input  8  Rojobot X location, world units.
REQ-008 locy_in  input  8  Rojobot Y location, world units.
REQ-009 vsync  input  1  vertical sync from display timing generator, polarity per VSYNC_ACTIVE_LOW.
REQ-010 botinfo_reg  output  8  frame-stable orientation/status to icon renderer.
REQ-011 locx_reg  output  8  frame-stable X location to icon renderer.
REQ-012 locy_reg  output  8  frame-stable Y location to icon renderer.
REQ-013 icon_en  output  1  renderer enable; 0 forces transparent icon.
REQ-014 upd_ack  output  1  one-cycle pulse when a pending update is committed to *_reg.
REQ-015 drop_cnt  output  8  count of updates overwritten before commit, saturating.

Function
REQ-016 vsync SHALL be double-flop synchronized; frame_start SHALL be a one-cycle internal pulse on the synchronized transition into the asserted level.
REQ-017 FSM states: IDLE (no pending data), PEND (shadow holds uncommitted data).
REQ-018 IDLE, upd_sysregs=1: capture *_in into shadow registers next edge, go PEND.
REQ-019 PEND, upd_sysregs=1 without frame_start: overwrite shadow, drop_cnt+1 (saturate at 255), stay PEND.
REQ-020 PEND, frame_start=1 without upd_sysregs: copy shadow to *_reg, upd_ack=1 that cycle+1, go IDLE.
REQ-021 PEND, both in same cycle: commit the older shadow to *_reg, capture new *_in into shadow, upd_ack=1, stay PEND, drop_cnt unchanged.
REQ-022 IDLE, upd_sysregs=1 and frame_start=1 same cycle: capture only, no commit, go PEND.
REQ-023 IDLE, frame_start alone: *_reg unchanged, no upd_ack.
REQ-024 *_reg SHALL change only on the edge following frame_start; never mid-frame.
REQ-025 Latency upd_sysregs -> *_reg: at most one frame plus 1 clk after next frame_start; upd_ack coincident with new *_reg value.
REQ-026 Frame counter frm_cnt (8 bit) SHALL increment on frame_start, wrapping to 0 when reaching BLINK_FRAMES-1.
REQ-027 Without blink feature, icon_en SHALL be 1 after reset.

Reset
REQ-028 reset_n low SHALL asynchronously force: state IDLE, shadow and *_reg to 0x00, upd_ack 0, drop_cnt 0, frm_cnt 0, icon_en 1, synchronizer flops to deasserted vsync level.
REQ-029 Reset asserted while PEND SHALL discard shadow data; no upd_ack after release.
REQ-030 First frame_start SHALL NOT be detected within 2 clk of reset release.

Configuration
REQ-031 Macro ICON_SCHED_BLINK_EN defined: when committed botinfo_reg[7:4] != 0, icon_en SHALL toggle each time frm_cnt wraps; when botinfo_reg[7:4] == 0, icon_en SHALL be 1 and frm_cnt held at 0.
REQ-032 Macro undefined: frm_cnt and blink logic absent; icon_en constant 1.

Verification
REQ-033 Reset, single upd_sysregs with locx_in=0x20, locy_in=0x18, botinfo_in=0x02, then vsync pulse -> *_reg = 0x20/0x18/0x02 two clk after synchronized edge, upd_ack single pulse, drop_cnt=0.
REQ-034 Three upd_sysregs pulses (locx 0x01,0x02,0x03) in one frame, then vsync -> locx_reg=0x03, drop_cnt=2, one upd_ack.
REQ-035 upd_sysregs (locx 0x05) pending, then upd_sysregs (locx 0x06) in exact frame_start cycle -> locx_reg=0x05, state PEND, next vsync -> locx_reg=0x06.
REQ-036 300 dropped updates -> drop_cnt saturates at 0xFF.
REQ-037 Assert reset_n low while PEND, release, vsync -> *_reg stay 0x00, no upd_ack.
REQ-038 ICON_SCHED_BLINK_EN defined, BLINK_FRAMES=4, committed botinfo=0x12 -> icon_en toggles every 4 frames; commit botinfo=0x02 -> icon_en=1 steady.

Source files
------------

// File: rtl/icon_sched.sv
// Frame-synchronous scheduler for Rojobot icon registers: buffers updates in a shadow and commits them on vsync.
// Optional blink feature enabled by defining ICON_SCHED_BLINK_EN.
module icon_sched #(
  parameter int unsigned BLINK_FRAMES     = 16,
  parameter int unsigned VSYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       upd_sysregs,
  input  logic [7:0] botinfo_in,
  input  logic [7:0] locx_in,
  input  logic [7:0] locy_in,
  input  logic       vsync,
  output logic [7:0] botinfo_reg,
  output logic [7:0] locx_reg,
  output logic [7:0] locy_reg,
  output logic       icon_en,
  output logic       upd_ack,
  output logic [7:0] drop_cnt
);

  localparam logic VS_ASSERT = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic VS_IDLE   = ~VS_ASSERT;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
    $error("icon_sched: BLINK_FRAMES must be in 1..255");
  end

  logic        vs_meta_q, vs_sync_q, vs_prev_q;
  logic        frame_start;
  logic [0:0]  state_q, state_d;
  logic [23:0] shadow_q, shadow_d;
  logic [23:0] disp_q, disp_d;
  logic        ack_q, ack_d;
  logic [7:0]  drop_q, drop_d;

  // The raw vsync level is kept in the flops, so reset parks them at the idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_meta_q <= VS_IDLE;
      vs_sync_q <= VS_IDLE;
      vs_prev_q <= VS_IDLE;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
    end
  end

  assign frame_start = (vs_sync_q == VS_ASSERT) && (vs_prev_q != VS_ASSERT);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    ack_d    = 1'b0;
    drop_d   = drop_q;
    case (state_q)
      IDLE: begin
        if (upd_sysregs) begin
          shadow_d = {botinfo_in, locx_in, locy_in};
          state_d  = PEND;
        end
      end
      PEND: begin
        if (frame_start) begin
          disp_d = shadow_q;
          ack_d  = 1'b1;
        end
        // A same-cycle update refills the shadow after its old contents were committed, so nothing is dropped.
        if (upd_sysregs) begin
          shadow_d = {botinfo_in, locx_in, locy_in};
          if (!frame_start && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end else if (frame_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      disp_q   <= '0;
      ack_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      ack_q    <= ack_d;
      drop_q   <= drop_d;
    end
  end

  assign botinfo_reg = disp_q[23:16];
  assign locx_reg    = disp_q[15:8];
  assign locy_reg    = disp_q[7:0];
  assign upd_ack     = ack_q;
  assign drop_cnt    = drop_q;

`ifdef ICON_SCHED_BLINK_EN
  localparam logic [7:0] FRM_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] frm_cnt_q, frm_cnt_d;
  logic       icon_en_q, icon_en_d;

  // Blinking follows the committed status nibble; a zero status parks the counter and shows the icon.
  always_comb begin
    frm_cnt_d = frm_cnt_q;
    icon_en_d = icon_en_q;
    if (disp_q[23:20] == 4'h0) begin
      frm_cnt_d = '0;
      icon_en_d = 1'b1;
    end else if (frame_start) begin
      if (frm_cnt_q == FRM_LAST) begin
        frm_cnt_d = '0;
        icon_en_d = ~icon_en_q;
      end else begin
        frm_cnt_d = frm_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frm_cnt_q <= '0;
      icon_en_q <= 1'b1;
    end else begin
      frm_cnt_q <= frm_cnt_d;
      icon_en_q <= icon_en_d;
    end
  end

  assign icon_en = icon_en_q;
`else
  assign icon_en = 1'b1;
`endif

endmodule

// File: tb/tb_icon_sched.sv
// Scoreboard bench for icon_sched: stimulus pushes hand-computed commits, a negedge monitor pops them on upd_ack.
module tb_icon_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       upd_sysregs;
  logic [7:0] botinfo_in, locx_in, locy_in;
  logic       vsync;
  logic [7:0] botinfo_reg, locx_reg, locy_reg;
  logic       icon_en, upd_ack;
  logic [7:0] drop_cnt;

  int unsigned pass_cnt = 0;
  int unsigned tot_cnt  = 0;

  typedef struct {
    logic [7:0] bot;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] drop;
  } exp_t;

  exp_t exp_q[$];

  icon_sched #(
    .BLINK_FRAMES(4),
    .VSYNC_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .upd_sysregs(upd_sysregs),
    .botinfo_in(botinfo_in),
    .locx_in(locx_in),
    .locy_in(locy_in),
    .vsync(vsync),
    .botinfo_reg(botinfo_reg),
    .locx_reg(locx_reg),
    .locy_reg(locy_reg),
    .icon_en(icon_en),
    .upd_ack(upd_ack),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_commit(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] d);
    exp_t e;
    e.bot = b; e.x = x; e.y = y; e.drop = d;
    exp_q.push_back(e);
  endtask

  task automatic upd(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
    botinfo_in = b; locx_in = x; locy_in = y;
    upd_sysregs = 1'b1;
    tick(1);
    upd_sysregs = 1'b0;
    tick(1);
  endtask

  task automatic frame();
    vsync = 1'b0;
    tick(4);
    vsync = 1'b1;
    tick(6);
  endtask

  // Lands the update exactly in the frame_start cycle (two edges after vsync falls).
  task automatic upd_at_fs(input logic [7:0] b, input logic [7:0] x, input logic [7:0] y);
    vsync = 1'b0;
    tick(2);
    botinfo_in = b; locx_in = x; locy_in = y;
    upd_sysregs = 1'b1;
    tick(1);
    upd_sysregs = 1'b0;
    tick(1);
    vsync = 1'b1;
    tick(6);
  endtask

  // Monitor: every ack must match the oldest expected commit; registers may not move without one.
  logic [23:0] prev_regs;
  logic        prev_ack;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_regs = {botinfo_reg, locx_reg, locy_reg};
      prev_ack  = upd_ack;
    end else begin
      if (upd_ack) begin
        chk("ack_single_pulse", {31'd0, prev_ack}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("botinfo_reg", {24'd0, botinfo_reg}, {24'd0, e.bot});
          chk("locx_reg", {24'd0, locx_reg}, {24'd0, e.x});
          chk("locy_reg", {24'd0, locy_reg}, {24'd0, e.y});
          chk("drop_cnt_at_ack", {24'd0, drop_cnt}, {24'd0, e.drop});
        end
      end else if ({botinfo_reg, locx_reg, locy_reg} != prev_regs) begin
        chk("regs_change_without_ack", {8'd0, botinfo_reg, locx_reg, locy_reg}, {8'd0, prev_regs});
      end
      prev_regs = {botinfo_reg, locx_reg, locy_reg};
      prev_ack  = upd_ack;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] iv;
    reset_n = 1'b0; vsync = 1'b1; upd_sysregs = 1'b0;
    botinfo_in = '0; locx_in = '0; locy_in = '0;
    tick(3);
    reset_n = 1'b1;
    tick(1);

    chk("reset_botinfo", {24'd0, botinfo_reg}, 32'h00);
    chk("reset_locx", {24'd0, locx_reg}, 32'h00);
    chk("reset_locy", {24'd0, locy_reg}, 32'h00);
    chk("reset_drop", {24'd0, drop_cnt}, 32'h00);
    chk("reset_ack", {31'd0, upd_ack}, 32'd0);
    chk("reset_icon_en", {31'd0, icon_en}, 32'd1);

    // IDLE: frame alone does nothing; update in frame_start cycle only captures.
    frame();
    upd_at_fs(8'h01, 8'hAA, 8'hBB);
    chk("idle_fs_no_commit", {24'd0, locx_reg}, 32'h00);
    expect_commit(8'h01, 8'hAA, 8'hBB, 8'h00);
    frame();

    // Single update then vsync.
    upd(8'h02, 8'h20, 8'h18);
    expect_commit(8'h02, 8'h20, 8'h18, 8'h00);
    frame();
    chk("single_drop", {24'd0, drop_cnt}, 32'h00);

    // Three updates in one frame: last wins, two drops.
    upd(8'h00, 8'h01, 8'h07);
    upd(8'h00, 8'h02, 8'h07);
    upd(8'h00, 8'h03, 8'h07);
    chk("triple_drop", {24'd0, drop_cnt}, 32'h02);
    expect_commit(8'h00, 8'h03, 8'h07, 8'h02);
    frame();

    // Pending update overlapped by a new one exactly at frame_start.
    upd(8'h00, 8'h05, 8'h09);
    expect_commit(8'h00, 8'h05, 8'h09, 8'h02);
    upd_at_fs(8'h00, 8'h06, 8'h09);
    chk("overlap_locx_old", {24'd0, locx_reg}, 32'h05);
    chk("overlap_drop_same", {24'd0, drop_cnt}, 32'h02);
    expect_commit(8'h00, 8'h06, 8'h09, 8'h02);
    frame();
    chk("overlap_locx_new", {24'd0, locx_reg}, 32'h06);

    // Reset while pending discards the shadow.
    upd(8'h02, 8'h33, 8'h44);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk("rst_pend_locx", {24'd0, locx_reg}, 32'h00);
    chk("rst_pend_drop", {24'd0, drop_cnt}, 32'h00);
    frame();
    chk("rst_pend_after_vs", {botinfo_reg, locx_reg, locy_reg}, 32'h0);

    // Drop counter saturation across 300 updates in one frame.
    for (int i = 0; i < 300; i++) begin
      iv = 8'(i);
      upd(8'h00, iv, 8'h11);
      if (i == 9)   chk("drop_9", {24'd0, drop_cnt}, 32'd9);
      if (i == 254) chk("drop_254", {24'd0, drop_cnt}, 32'd254);
      if (i == 255) chk("drop_255", {24'd0, drop_cnt}, 32'd255);
    end
    chk("drop_sat", {24'd0, drop_cnt}, 32'hFF);
    expect_commit(8'h00, 8'h2B, 8'h11, 8'hFF);
    frame();

`ifdef ICON_SCHED_BLINK_EN
    begin
      logic [8:1] blink_exp;
      blink_exp = 8'b1000_0111;
      upd(8'h12, 8'h40, 8'h50);
      expect_commit(8'h12, 8'h40, 8'h50, 8'hFF);
      frame();
      chk("blink_start", {31'd0, icon_en}, 32'd1);
      for (int f = 1; f <= 8; f++) begin
        frame();
        chk("blink_frame", {31'd0, icon_en}, {31'd0, blink_exp[f]});
      end
      upd(8'h02, 8'h41, 8'h51);
      expect_commit(8'h02, 8'h41, 8'h51, 8'hFF);
      frame();
      for (int f = 0; f < 5; f++) begin
        chk("blink_steady", {31'd0, icon_en}, 32'd1);
        frame();
      end
    end
`else
    for (int f = 0; f < 3; f++) begin
      chk("icon_en_const", {31'd0, icon_en}, 32'd1);
      frame();
    end
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
